// File: rtl/sim_result_monitor.sv
// End-of-test monitor: watches DMEM stores and retires for tohost pass/fail,
// timeout or retire hang, and captures a signature window with a running checksum.
module sim_result_monitor #(
    parameter logic [31:0] TOHOST_ADDR    = 32'h0001_FFF0,
    parameter logic [31:0] SIG_BASE       = 32'h0001_0000,
    parameter int          SIG_WORDS      = 16,
    parameter int          CNT_W          = 32,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter int          HANG_CYCLES    = 64,
    localparam int         IDX_W          = (SIG_WORDS > 1) ? $clog2(SIG_WORDS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_wdata,
    input  logic [3:0]       st_be,
    input  logic             retire_valid,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [2:0]       status,
    output logic [30:0]      fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count,
    input  logic [IDX_W-1:0] sig_rd_idx,
    output logic [31:0]      sig_rd_data,
    output logic [31:0]      sig_checksum
);

    // state      | meaning
    // ST_IDLE    | out of reset, waiting for the first enabled cycle
    // ST_RUN     | monitoring: counting, capturing, checking
    // ST_PASS    | tohost reported pass (sticky)
    // ST_FAIL    | tohost reported a failure code (sticky)
    // ST_TIMEOUT | active cycle budget exhausted (sticky)
    // ST_HANG    | too many active cycles without a retire (sticky)
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4,
        ST_HANG    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE      = 1;
    localparam bit               TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam bit               HANG_EN      = (HANG_CYCLES != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HANG_LAST    = CNT_W'(HANG_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] stall_count;
    logic [31:0]      sig_mem [SIG_WORDS];

    logic             active;
    logic [29:0]      word_off;
    logic             in_win;
    logic             capture;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      be_mask;
    logic             tohost_hit;
    logic             timeout_hit;
    logic             hang_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    assign active   = enable && (state == ST_IDLE || state == ST_RUN);
    // Explicit lower-bound test keeps addresses below the base from wrapping into the window.
    assign word_off = st_addr[31:2] - SIG_BASE[31:2];
    assign in_win   = (st_addr[31:2] >= SIG_BASE[31:2]) && (word_off < 30'(SIG_WORDS));
    assign capture  = active && st_valid && in_win;
    assign wr_idx   = word_off[IDX_W-1:0];
    assign be_mask  = {{8{st_be[3]}}, {8{st_be[2]}}, {8{st_be[1]}}, {8{st_be[0]}}};

    assign tohost_hit  = st_valid && (st_addr[31:2] == TOHOST_ADDR[31:2])
                         && (st_be == 4'hF) && st_wdata[0];
    assign timeout_hit = TIMEOUT_EN && (cycle_count == TIMEOUT_LAST);
    assign hang_hit    = HANG_EN && !retire_valid && (stall_count == HANG_LAST);

    assign status      = state;
    assign sig_rd_data = sig_mem[sig_rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            fail_code    <= '0;
            cycle_count  <= '0;
            retire_count <= '0;
            stall_count  <= '0;
            sig_checksum <= '0;
            for (int i = 0; i < SIG_WORDS; i++) begin
                sig_mem[i] <= '0;
            end
        end else if (active) begin
            cycle_count <= sat_inc(cycle_count);
            if (retire_valid) begin
                retire_count <= sat_inc(retire_count);
                stall_count  <= '0;
            end else begin
                stall_count  <= sat_inc(stall_count);
            end

            if (capture) begin
                for (int b = 0; b < 4; b++) begin
                    if (st_be[b]) begin
                        sig_mem[wr_idx][8*b +: 8] <= st_wdata[8*b +: 8];
                    end
                end
                sig_checksum <= {sig_checksum[30:0], sig_checksum[31]} ^ (st_wdata & be_mask);
            end

            if (tohost_hit) begin
                done <= 1'b1;
                if (st_wdata == 32'h1) begin
                    state <= ST_PASS;
                    pass  <= 1'b1;
                end else begin
                    state     <= ST_FAIL;
                    fail      <= 1'b1;
                    fail_code <= st_wdata[31:1];
                end
            end else if (hang_hit) begin
                state <= ST_HANG;
                done  <= 1'b1;
                fail  <= 1'b1;
            end else if (timeout_hit) begin
                state <= ST_TIMEOUT;
                done  <= 1'b1;
                fail  <= 1'b1;
            end else begin
                state <= ST_RUN;
            end
        end
    end

endmodule

// File: doc/sim_result_monitor.md
Name: sim_result_monitor

Overview:
- Synthesizable end-of-test monitor for the RV32I pipeline core. It replaces fixed-cycle "run N cycles then peek" checking with event-driven completion.
- Snoops the core's data-memory store port and retire strobe.
- Detects a tohost pass/fail write, a global timeout, or a retire hang.
- Captures a signature window of memory stores into a readable buffer and keeps a running checksum of those stores.
- Instantiated beside the DMEM in bench tops and FPGA debug builds.

Parameters:
TOHOST_ADDR, 32'h0001_FFF0, word address watched for the pass/fail code.
SIG_BASE, 32'h0001_0000, byte base of the signature window (word aligned).
SIG_WORDS, 16, number of 32-bit words captured (power of 2, 1..256).
CNT_W, 32, width of the cycle and retire counters.
TIMEOUT_CYCLES, 100000, active cycles allowed before TIMEOUT; 0 disables the timeout.
HANG_CYCLES, 64, consecutive active cycles without a retire before HANG; 0 disables hang detection.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  monitoring enable; low pauses counting and capture
st_valid  in  1  store committed to DMEM this cycle
st_addr  in  32  store byte address; bits [1:0] ignored
st_wdata  in  32  store data, lane aligned
st_be  in  4  store byte enables
retire_valid  in  1  one instruction retired this cycle
done  out  1  terminal state reached
pass  out  1  tohost reported pass
fail  out  1  tohost reported fail, timeout, or hang
status  out  3  0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT, 5 HANG
fail_code  out  31  st_wdata[31:1] of the failing tohost write
cycle_count  out  CNT_W  active cycles spent in RUN
retire_count  out  CNT_W  retires counted in RUN
sig_rd_idx  in  log2(SIG_WORDS)  signature read index
sig_rd_data  out  32  captured word at sig_rd_idx (combinational read)
sig_checksum  out  32  running checksum of window stores

Behaviour:
- Reset (rst_n low, asynchronous):
  - status=IDLE; done, pass, fail = 0.
  - fail_code, cycle_count, retire_count, sig_checksum = 0; stall counter = 0.
  - All signature words = 0.
  - Reset mid-run returns to IDLE immediately.
- IDLE -> RUN on the first cycle with enable=1. That cycle is already active: it counts and captures.
- Active cycle = status RUN and enable=1. In RUN with enable=0, every register holds and all inputs are ignored.
- Each active cycle:
  - cycle_count += 1.
  - retire_valid: retire_count += 1 and the stall counter clears; otherwise the stall counter += 1.
  - All counters saturate at all-ones and never wrap.
- Tohost event: st_valid, word address == TOHOST_ADDR[31:2], and st_be == 4'hF.
  - st_wdata == 1 -> PASS.
  - st_wdata[0] == 1, any other value -> FAIL, with fail_code = st_wdata[31:1].
  - st_wdata[0] == 0 -> ignored.
  - Partial-width stores to tohost -> ignored.
- Timeout: an active cycle whose pre-increment cycle_count == TIMEOUT_CYCLES-1 -> TIMEOUT. done therefore rises after exactly TIMEOUT_CYCLES active cycles.
- Hang: an active cycle with no retire whose pre-increment stall counter == HANG_CYCLES-1 -> HANG.
- Same-cycle priority: tohost > HANG > TIMEOUT.
- Latency: status and flags are registered. They update on the clock edge ending the triggering cycle. The triggering cycle's counter increments still apply.
- Outputs by state:
  - done=1 in PASS, FAIL, TIMEOUT and HANG.
  - pass=1 only in PASS.
  - fail=1 in FAIL, TIMEOUT and HANG.
- Terminal states are sticky until reset. Counters, capture and checksum freeze.
- Signature capture, for an active st_valid with word offset k = (st_addr - SIG_BASE)>>2 in [0, SIG_WORDS):
  - Each byte lane b with st_be[b]=1 overwrites byte b of word k. The other bytes are kept.
  - Addresses outside the window are ignored, with no aliasing from unsigned underflow.
  - A tohost address inside the window is both captured and evaluated.
- Checksum, on every captured store: sig_checksum <= {sig_checksum[30:0], sig_checksum[31]} ^ (st_wdata & byte-mask(st_be)).
- sig_rd_data reflects the stored contents and is updated from the cycle after a write.

Test Plan:
- Reset, enable=1, retire every cycle, then word store of 32'h1 to 0x0001_FFF0 on active cycle 50 -> next edge: status=2, done=1, pass=1, fail=0, cycle_count=50; values frozen for 20 further cycles.
- Word store of 32'h0000_0007 to tohost -> status=3, fail=1, fail_code=3. An sb of 0x01 to tohost beforehand is ignored (status stays 1).
- TIMEOUT_CYCLES=100, HANG_CYCLES=0, no tohost write -> done rises after 100 active cycles with status=4 and cycle_count=100. Toggling enable low for 10 cycles mid-run delays done by exactly 10 cycles.
- HANG_CYCLES=8, retire pulses stop -> status=5 after 8 retire-free active cycles. A retire on stall cycle 7 restarts the count.
- Stores sw 10, sw 20, sw 0xFFFF_FFFB, sw 15 to 0x10000..0x1000C, then sb 0xAA to 0x10001, plus a store to 0x0000_FFFC -> sig words [0..3] = 0x0000AA0A, 20, 0xFFFFFFFB, 15. sig_checksum matches the reference model; word index SIG_WORDS-1 stays unchanged.
- Same cycle: tohost pass write, hang threshold and timeout threshold all hit -> status=2 (PASS). Then assert rst_n low mid-terminal -> immediate IDLE with all outputs zero.
